fht_load_ctrl: RTL

Input loader for the FHT core: accepts a stream of time-domain samples over a valid/ready handshake and writes them into the four data banks. Addresses are bit-reversed so the banks hold the ordering `fht_control` expects at stage 0. After the last sample it pulses `fht_control`'s start, then blocks new input until the transform completes. It sits directly upstream of `fht_control` and shares the bank write ports with it through the existing source mux.

---
 rtl/fht_pkg.sv | 46 ++++
 rtl/fht_load_ctrl_if.sv | 40 ++++
 rtl/fht_bitrev.sv | 19 +
 rtl/fht_load_ctrl.sv | 94 +++++++++
 4 files changed

// File: rtl/fht_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fht_pkg
//  Purpose  : Shared FHT definitions: loader state encoding, frame-size helpers
//             derived from the bank address width, and a bit-reverse function
//             that the output reader also uses.
//  Revision : 1.0  initial release
// ============================================================================
package fht_pkg;

  // Loader control states.
  typedef enum logic [2:0] {
    S_LOAD      = 3'd0,
    S_FLUSH     = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } load_state_t;

  // Frame geometry for the default bank address width.
  localparam int A_BIT_DEFAULT = 8;
  localparam int N_BIT         = A_BIT_DEFAULT + 2;
  localparam int N_POINTS      = 4 << A_BIT_DEFAULT;

  // Sample-index width for a given bank address width (4 banks -> +2 bits).
  function automatic int n_bit(input int a_bit);
    return a_bit + 2;
  endfunction

  // Points per frame for a given bank address width.
  function automatic int n_points(input int a_bit);
    return 4 << a_bit;
  endfunction

  // Reverse the low 'width' bits of 'value'; bits above 'width' come back 0.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[i] = value[width-1-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fht_load_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fht_load_ctrl_if
//  Purpose  : Sample-stream handshake, FHT start/ready pair and bank write
//             port of the FHT input loader.
//  Ports    : iDATA/iVALID/oREADY    sample stream
//             iFHT_RDY/oSTART         handshake with fht_control
//             oADDR_WR/oDATA/oWE_0..3 bank write port
//             oBUSY                   frame in progress
//  Modports : master - loader side; slave - surrounding environment
//  Revision : 1.0  initial release
// ============================================================================
interface fht_load_ctrl_if #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
);
  logic [D_BIT-1:0] iDATA;
  logic             iVALID;
  logic             oREADY;
  logic             iFHT_RDY;
  logic             oSTART;
  logic [A_BIT-1:0] oADDR_WR;
  logic [D_BIT-1:0] oDATA;
  logic             oWE_0;
  logic             oWE_1;
  logic             oWE_2;
  logic             oWE_3;
  logic             oBUSY;

  modport master (
    input  iDATA, iVALID, iFHT_RDY,
    output oREADY, oSTART, oADDR_WR, oDATA, oWE_0, oWE_1, oWE_2, oWE_3, oBUSY
  );

  modport slave (
    output iDATA, iVALID, iFHT_RDY,
    input  oREADY, oSTART, oADDR_WR, oDATA, oWE_0, oWE_1, oWE_2, oWE_3, oBUSY
  );
endinterface
`default_nettype wire

// File: rtl/fht_bitrev.sv
`default_nettype none
// ============================================================================
//  Module   : fht_bitrev
//  Purpose  : Combinational bit reversal of a WIDTH-bit index (pure wiring).
//  Ports    : in_bits  - index in natural order
//             out_bits - index with bit order reversed
//  Revision : 1.0  initial release
// ============================================================================
module fht_bitrev #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] in_bits,
  output logic [WIDTH-1:0] out_bits
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign out_bits[i] = in_bits[WIDTH-1-i];
  end
endmodule
`default_nettype wire

// File: rtl/fht_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fht_load_ctrl
//  Purpose  : FHT input loader. Accepts one frame of N = 4*2^A_BIT samples over
//             valid/ready, writes each into one of four banks at a (by default
//             bit-reversed) position, then pulses the FHT start and holds off
//             new input until the transform reports ready again.
//  Ports    : iCLK, iRESET (synchronous, active high)
//             bus (fht_load_ctrl_if.master): stream in, bank write port out,
//             start/ready handshake with fht_control, busy flag.
//  Config   : FHT_LOAD_BIT_REV_EN - defined: target index = bitrev(n);
//             undefined: target index = n (natural order). Timing is identical.
//  Revision : 1.0  initial release
// ============================================================================
module fht_load_ctrl
  import fht_pkg::*;
#(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) (
  input  logic iCLK,
  input  logic iRESET,
  fht_load_ctrl_if.master bus
);

  localparam int              NB     = n_bit(A_BIT);
  localparam logic [NB-1:0]   LAST_N = NB'(n_points(A_BIT) - 1);

  load_state_t      r_state;
  load_state_t      w_state_nxt;
  logic [NB-1:0]    r_n;
  logic [NB-1:0]    w_r;
  logic [3:0]       r_we;
  logic [A_BIT-1:0] r_addr;
  logic [D_BIT-1:0] r_data;
  logic             w_accept;

  assign w_accept = bus.iVALID & (r_state == S_LOAD);

`ifdef FHT_LOAD_BIT_REV_EN
  fht_bitrev #(.WIDTH(NB)) u_bitrev (
    .in_bits  (r_n),
    .out_bits (w_r)
  );
`else
  assign w_r = r_n;
`endif

  // Counter wraps to 0 on its own after the last sample of a frame.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_state <= S_LOAD;
      r_n     <= '0;
      r_we    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_n    <= r_n + 1'b1;
        r_we   <= 4'b0001 << w_r[1:0];
        r_addr <= w_r[NB-1:2];
        r_data <= bus.iDATA;
      end else begin
        r_we   <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:      if (w_accept && (r_n == LAST_N)) w_state_nxt = S_FLUSH;
      S_FLUSH:     w_state_nxt = S_START;
      S_START:     w_state_nxt = S_WAIT_BUSY;
      // Wait for the FHT to acknowledge start before watching for completion.
      S_WAIT_BUSY: if (!bus.iFHT_RDY) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.iFHT_RDY)  w_state_nxt = S_LOAD;
      default:     w_state_nxt = S_LOAD;
    endcase
  end

  assign bus.oREADY   = (r_state == S_LOAD);
  assign bus.oSTART   = (r_state == S_START);
  assign bus.oBUSY    = (r_n != '0) || (r_state != S_LOAD);
  assign bus.oADDR_WR = r_addr;
  assign bus.oDATA    = r_data;
  assign bus.oWE_0    = r_we[0];
  assign bus.oWE_1    = r_we[1];
  assign bus.oWE_2    = r_we[2];
  assign bus.oWE_3    = r_we[3];

endmodule
`default_nettype wire
